// File: rtl/mips_main_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mips_main_control_fsm_pkg
//
// Purpose : Shared definitions for the multicycle MIPS main-control FSM:
//           state encodings (13 states in 4 bits), the opcodes the control
//           unit understands, and the datapath mux/ALUOp select encodings.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package mips_main_control_fsm_pkg;

    // Controller states. The encoding is visible on the debug 'state' port,
    // so it is pinned explicitly rather than left to the enum default.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    // Opcodes decoded in DECODE; anything else is illegal.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALUOp to alu_control.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that present a request to memory and wait on mem_ready.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mips_main_control_fsm_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mips_main_control_fsm_mem_wait_timer  (the mem_wait_timer)
//
// Purpose : Watchdog for the memory handshake. Counts cycles spent waiting
//           on mem_ready and flags 'expired' on the last allowed wait cycle,
//           so the controller can divert to FAULT on the next edge.
//           MEM_TIMEOUT = 0 disables the watchdog entirely.
// Ports   : clk     in  system clock
//           rst     in  synchronous active-high reset (clears the count)
//           clear   in  restart the count (state change or mem_ready)
//           count   in  a waited cycle: in a memory state with mem_ready=0
//           expired out this waited cycle is the MEM_TIMEOUT-th one
// ---------------------------------------------------------------------------
module mips_main_control_fsm_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    // A zero timeout still needs a legal one-bit register.
    localparam int W        = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int LAST_INT = (MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [W-1:0] LAST    = LAST_INT[W-1:0];
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic         ENABLED = (MEM_TIMEOUT > 0);

    logic [W-1:0] timer;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            timer <= '0;
        end else if (count && (timer != CNT_MAX)) begin
            // Saturate instead of wrapping (only reachable when disabled).
            timer <= timer + W'(1);
        end
    end

    // The timer holds the number of waits already completed, so the
    // MEM_TIMEOUT-th consecutive waited cycle sees timer == MEM_TIMEOUT-1.
    assign expired = ENABLED && count && (timer == LAST);

endmodule

// File: rtl/mips_main_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_main_control_fsm
//
// Purpose : Main control unit of a multicycle MIPS. Sequences
//           FETCH/DECODE/EXECUTE/MEM/WB per opcode and drives the datapath
//           enables as Moore outputs of the current state (FETCH's IRWrite
//           and PCWrite are additionally qualified by mem_ready). Memory
//           states wait on a mem_ready handshake guarded by a watchdog;
//           illegal opcodes and watchdog expiry enter a sticky FAULT state
//           that only rst leaves. The funct field is not examined here:
//           ALUOp=10 tells alu_control to decode it.
// Ports   : clk, rst (sync, active high)
//           op[5:0]      opcode from the instruction register
//           mem_ready    memory completes the current request this cycle
//           mem_req      memory request active
//           IorD         0=PC address, 1=ALUOut address
//           IRWrite      load instruction register
//           MemWrite     memory write strobe
//           RegDst       0=rt, 1=rd
//           MemtoReg     0=ALUOut, 1=memory data
//           RegWrite     register file write enable
//           ALUSrcA      0=PC, 1=rs
//           ALUSrcB[1:0] 00=rt, 01=4, 10=signext imm, 11=signext imm<<2
//           ALUOp[1:0]   00=add, 01=sub, 10=funct decode
//           PCSrc[1:0]   00=ALU result, 01=ALUOut, 10=jump target
//           PCWrite      unconditional PC write
//           Branch       PC write qualified by zero in the datapath
//           instr_done   pulse on the final cycle of each instruction
//           fault        high while in FAULT
//           state[3:0]   current state encoding (debug)
// ---------------------------------------------------------------------------
module mips_main_control_fsm
    import mips_main_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;

    logic wait_count;
    logic timer_clear;
    logic timer_expired;

    // -----------------------------------------------------------------------
    // Memory watchdog
    // -----------------------------------------------------------------------
    // mem_ready is only meaningful in the three memory states; elsewhere it
    // neither counts nor matters (a stray clear outside them is harmless).
    assign wait_count  = is_mem_state(state_q) && !mem_ready;
    assign timer_clear = (state_d != state_q) || mem_ready;

    mips_main_control_fsm_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .count   (wait_count),
        .expired (timer_expired)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                // A ready on the expiry cycle still counts as progress.
                if (mem_ready)          state_d = S_DECODE;
                else if (timer_expired) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEXEC;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready)          state_d = S_MEMWB;
                else if (timer_expired) state_d = S_FAULT;
            end
            S_MEMWRITE: begin
                if (mem_ready)          state_d = S_FETCH;
                else if (timer_expired) state_d = S_FAULT;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            // Unused encodings are treated as a fault rather than recovered.
            default:    state_d = S_FAULT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_ALU;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed,
                // together with the IR load, once memory returns the word.
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm<<2) into ALUOut.
                ALUSrcB = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                // The strobe is held for the whole wait; the store completes
                // on the cycle memory signals ready.
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_SUB;
                PCSrc      = PCSRC_ALUOUT;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase

        // Reset suppresses every side effect in the cycle it is applied,
        // whatever state the controller happens to be in.
        if (rst) begin
            mem_req    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_main_control_fsm
//
// Self-checking bench for mips_main_control_fsm with a short watchdog.
// Each instruction is expanded into a plan: the ordered list of phases the
// controller should visit (with the mem_ready value to drive in each),
// including handshake waits and watchdog faults. Every cycle the DUT
// outputs are compared with the outputs the phase requires, and each
// completed instruction's done pulse is compared with its latency.
// ---------------------------------------------------------------------------
module tb_mips_main_control_fsm;
    import mips_main_control_fsm_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_in = 6'h00;
    logic       mem_ready = 1'b0;

    logic       mem_req, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, PCWrite, Branch, instr_done, fault;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;

    mips_main_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op_in),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .instr_done (instr_done),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, iord, ir_write, mem_write;
        logic       reg_dst, memto_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       pc_write, branch, instr_done, fault;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        state_t ph;
        logic   mr;
    } step_t;

    ctl_t  obs;
    assign obs = {mem_req, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, instr_done,
                  fault, state};

    step_t plan[$];
    bit    plan_faulted;
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return o == OP_RTYPE || o == OP_LW || o == OP_SW ||
               o == OP_BEQ || o == OP_ADDI || o == OP_J;
    endfunction

    // Zero-wait cycle count of each instruction class.
    function automatic int base_latency(logic [5:0] o);
        case (o)
            OP_RTYPE: return 4;
            OP_LW:    return 5;
            OP_SW:    return 4;
            OP_BEQ:   return 3;
            OP_ADDI:  return 4;
            default:  return 3;
        endcase
    endfunction

    // Datapath controls each phase requires.
    function automatic ctl_t expect_ctl(state_t ph, logic mr, logic r);
        ctl_t e = '0;
        e.state = ph;
        case (ph)
            S_FETCH:    begin e.mem_req = 1; e.alu_src_b = 2'b01;
                              e.ir_write = mr; e.pc_write = mr; end
            S_DECODE:   e.alu_src_b = 2'b11;
            S_MEMADR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MEMREAD:  begin e.mem_req = 1; e.iord = 1; end
            S_MEMWB:    begin e.memto_reg = 1; e.reg_write = 1; e.instr_done = 1; end
            S_MEMWRITE: begin e.mem_req = 1; e.iord = 1; e.mem_write = 1;
                              e.instr_done = mr; end
            S_EXECUTE:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            S_ALUWB:    begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; end
            S_BRANCH:   begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
                              e.branch = 1; e.instr_done = 1; end
            S_ADDIEXEC: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_ADDIWB:   begin e.reg_write = 1; e.instr_done = 1; end
            S_JUMP:     begin e.pc_src = 2'b10; e.pc_write = 1; e.instr_done = 1; end
            S_FAULT:    e.fault = 1;
            default:    ;
        endcase
        if (r) begin
            e.mem_req = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0;
            e.pc_write = 0; e.branch = 0; e.instr_done = 0;
        end
        return e;
    endfunction

    task automatic add(state_t ph);
        if (!plan_faulted) plan.push_back('{ph, rbit()});
    endtask

    // A memory phase: 'waits' not-ready cycles, then ready, unless the wait
    // budget runs out first, in which case the next phase is FAULT.
    task automatic add_mem(state_t ph, int waits);
        if (plan_faulted) return;
        for (int i = 0; i < waits && i < TO; i++) plan.push_back('{ph, 1'b0});
        if (waits >= TO) begin
            plan.push_back('{S_FAULT, rbit()});
            plan_faulted = 1;
        end else begin
            plan.push_back('{ph, 1'b1});
        end
    endtask

    task automatic build_plan(logic [5:0] o, int wf, int wm);
        plan.delete();
        plan_faulted = 0;
        add_mem(S_FETCH, wf);
        add(S_DECODE);
        case (o)
            OP_RTYPE: begin add(S_EXECUTE); add(S_ALUWB); end
            OP_LW:    begin add(S_MEMADR); add_mem(S_MEMREAD, wm); add(S_MEMWB); end
            OP_SW:    begin add(S_MEMADR); add_mem(S_MEMWRITE, wm); end
            OP_BEQ:   add(S_BRANCH);
            OP_ADDI:  begin add(S_ADDIEXEC); add(S_ADDIWB); end
            OP_J:     add(S_JUMP);
            default:  if (!plan_faulted) begin
                          plan.push_back('{S_FAULT, rbit()});
                          plan_faulted = 1;
                      end
        endcase
        // FAULT must persist whatever mem_ready does.
        if (plan_faulted)
            for (int i = 0; i < 3; i++) plan.push_back('{S_FAULT, rbit()});
    endtask

    // Two-cycle reset; returns at a falling edge with rst low, in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = rbit();
        op_in = 6'($urandom);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH; starts and ends at a falling edge.
    task automatic run_plan(logic [5:0] o, int wf, int wm, string name);
        int   done_cnt = 0;
        int   done_at  = -1;
        int   lat;
        ctl_t exp;
        build_plan(o, wf, wm);
        for (int i = 0; i < plan.size(); i++) begin
            // The opcode only has to be valid from DECODE onward.
            op_in     = (plan[i].ph == S_FETCH) ? 6'($urandom) : o;
            mem_ready = plan[i].mr;
            #1;
            exp = expect_ctl(plan[i].ph, plan[i].mr, 1'b0);
            n_total++;
            if (obs !== exp)
                $display("FAIL %s cycle %0d: outputs got %h, want %h", name, i, obs, exp);
            else
                n_pass++;
            if (instr_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            @(negedge clk);
        end
        if (!plan_faulted) begin
            lat = base_latency(o) + wf + ((o == OP_LW || o == OP_SW) ? wm : 0);
            n_total++;
            if (done_cnt !== 1 || done_at !== lat - 1)
                $display("FAIL %s latency: done count %0d at cycle %0d, want 1 at %0d",
                         name, done_cnt, done_at + 1, lat);
            else
                n_pass++;
        end else begin
            do_reset();
        end
    endtask

    task automatic test_reset();
        ctl_t exp;
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            exp = expect_ctl(S_FETCH, 1'b1, 1'b1);
            n_total++;
            if (obs !== exp) $display("FAIL reset_hold %0d: outputs got %h, want %h", c, obs, exp);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp = expect_ctl(S_FETCH, 1'b1, 1'b0);
        n_total++;
        if (obs !== exp || IRWrite !== 1'b1 || PCWrite !== 1'b1 || fault !== 1'b0)
            $display("FAIL reset_release: outputs got %h, want %h", obs, exp);
        else n_pass++;
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_rtype();
        run_plan(OP_RTYPE, 0, 0, "rtype");
        run_plan(OP_ADDI, 0, 0, "addi");
    endtask

    task automatic test_lw_wait();
        run_plan(OP_LW, 0, 3, "lw_wait3");
        run_plan(OP_SW, 1, 2, "sw_wait");
    endtask

    task automatic test_branch_jump();
        run_plan(OP_BEQ, 0, 0, "beq");
        run_plan(OP_J, 0, 0, "jump");
    endtask

    task automatic test_timeout();
        run_plan(OP_RTYPE, TO, 0, "fetch_timeout");
        run_plan(OP_LW, 0, TO, "memread_timeout");
        run_plan(OP_SW, 0, TO, "memwrite_timeout");
        run_plan(OP_SW, TO - 1, TO - 1, "ready_on_expiry");
    endtask

    task automatic test_illegal();
        run_plan(6'h3F, 0, 0, "illegal_3f");
        run_plan(6'h05, 2, 0, "illegal_05");
    endtask

    task automatic test_reset_mid_memwrite();
        ctl_t exp;
        op_in = OP_SW;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        exp = expect_ctl(S_MEMWRITE, 1'b0, 1'b0);
        n_total++;
        if (obs !== exp) $display("FAIL midwrite_wait: outputs got %h, want %h", obs, exp);
        else n_pass++;
        rst = 1'b1;
        #1;
        exp = expect_ctl(S_MEMWRITE, 1'b0, 1'b1);
        n_total++;
        if (obs !== exp || MemWrite !== 1'b0)
            $display("FAIL midwrite_reset: outputs got %h, want %h", obs, exp);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        // A stale wait count would fault before the fourth FETCH cycle.
        run_plan(OP_RTYPE, TO - 1, 0, "after_midwrite_reset");
    endtask

    task automatic test_back_to_back();
        logic [5:0] o;
        int         wf, wm;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do o = 6'($urandom); while (is_legal(o));
            end else begin
                case ($urandom_range(0, 5))
                    0: o = OP_RTYPE;
                    1: o = OP_LW;
                    2: o = OP_SW;
                    3: o = OP_BEQ;
                    4: o = OP_ADDI;
                    default: o = OP_J;
                endcase
            end
            wf = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
            wm = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
            run_plan(o, wf, wm, "random");
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_timeout();
        test_illegal();
        test_reset_mid_memwrite();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
